// File: rtl/game_sequencer.sv
`default_nettype none
// game_sequencer: attract -> playing -> level-clear / game-over flow controller (36 MHz domain).
// Optional GAME_SEQUENCER_LIVES_EN adds a 3-life counter on o_lives. Rev 1.0
module game_sequencer #(
  parameter int LAST_LINE    = 12,
  parameter int CLEAR_FRAMES = 120,
  parameter int OVER_FRAMES  = 180,
  parameter int FRAME_CNT_W  = 8
) (
  input  logic        i_clk_36MHz,
  input  logic        i_reset,
  input  logic        i_vsync,
  input  logic        i_start_debounced,
  input  logic [19:0] i_invaders_array,
  input  logic [3:0]  i_invaders_line,
  output logic [1:0]  o_gameplay,
  output logic        o_clear,
  output logic        o_clear_score,
  output logic        o_level,
  output logic        o_enable,
  output logic [1:0]  o_lives
);

  typedef enum logic [1:0] {
    ST_ATTRACT     = 2'b00,
    ST_PLAYING     = 2'b01,
    ST_LEVEL_CLEAR = 2'b10,
    ST_GAME_OVER   = 2'b11
  } state_t;

  localparam logic [3:0]             LAST_LINE_V = 4'(LAST_LINE);
  localparam logic [FRAME_CNT_W-1:0] CLEAR_CNT   = FRAME_CNT_W'(CLEAR_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] OVER_CNT    = FRAME_CNT_W'(OVER_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] CNT_MAX     = '1;

  state_t                 state, state_next;
  logic                   vsync_d, start_d, frame_tick, start_evt;
  logic [FRAME_CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic                   armed, armed_next;
  logic                   clear, clear_next;
  logic                   clear_score, clear_score_next;
  logic                   level, level_next;
  logic                   enable;
  logic                   new_game, loss;
`ifdef GAME_SEQUENCER_LIVES_EN
  logic [1:0]             lives, lives_next;
`endif

  always_ff @(posedge i_clk_36MHz) begin
    if (i_reset) begin
      state       <= ST_ATTRACT;
      vsync_d     <= 1'b0;
      start_d     <= 1'b0;
      frame_tick  <= 1'b0;
      start_evt   <= 1'b0;
      cnt         <= '0;
      armed       <= 1'b0;
      clear       <= 1'b0;
      clear_score <= 1'b0;
      level       <= 1'b0;
      enable      <= 1'b0;
`ifdef GAME_SEQUENCER_LIVES_EN
      lives       <= 2'd3;
`endif
    end else begin
      vsync_d     <= i_vsync;
      frame_tick  <= vsync_d & ~i_vsync;
      start_d     <= i_start_debounced;
      start_evt   <= i_start_debounced & ~start_d;
      state       <= state_next;
      cnt         <= cnt_next;
      armed       <= armed_next;
      clear       <= clear_next;
      clear_score <= clear_score_next;
      level       <= level_next;
      enable      <= (state_next == ST_PLAYING);
`ifdef GAME_SEQUENCER_LIVES_EN
      lives       <= lives_next;
`endif
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    armed_next       = armed;
    clear_next       = 1'b0;
    clear_score_next = 1'b0;
    level_next       = level;
    new_game         = 1'b0;
    loss             = 1'b0;
    cnt_inc          = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
`ifdef GAME_SEQUENCER_LIVES_EN
    lives_next       = lives;
`endif

    case (state)
      ST_ATTRACT: begin
        if (start_evt) new_game = 1'b1;
      end
      ST_PLAYING: begin
        // The bitmap is stale until the reload settles, so checks wait one frame.
        if (!armed) begin
          if (frame_tick) armed_next = 1'b1;
        end else if (i_invaders_array == 20'd0) begin
          state_next = ST_LEVEL_CLEAR;
          cnt_next   = '0;
        end else if (i_invaders_line >= LAST_LINE_V) begin
          loss = 1'b1;
        end
      end
      ST_LEVEL_CLEAR: begin
        if (cnt == CLEAR_CNT) begin
          state_next = ST_PLAYING;
          clear_next = 1'b1;
          level_next = 1'b1;
          armed_next = 1'b0;
        end else if (frame_tick) begin
          cnt_next = cnt_inc;
        end
      end
      ST_GAME_OVER: begin
        if (start_evt && (cnt == OVER_CNT)) begin
          new_game = 1'b1;
        end else if (frame_tick && (cnt != OVER_CNT)) begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = ST_ATTRACT;
    endcase

    if (loss) begin
`ifdef GAME_SEQUENCER_LIVES_EN
      if (lives > 2'd1) begin
        lives_next = lives - 2'd1;
        clear_next = 1'b1;
        armed_next = 1'b0;
      end else begin
        lives_next = 2'd0;
        state_next = ST_GAME_OVER;
        cnt_next   = '0;
      end
`else
      state_next = ST_GAME_OVER;
      cnt_next   = '0;
`endif
    end

    if (new_game) begin
      state_next       = ST_PLAYING;
      clear_next       = 1'b1;
      clear_score_next = 1'b1;
      level_next       = 1'b0;
      armed_next       = 1'b0;
      cnt_next         = '0;
`ifdef GAME_SEQUENCER_LIVES_EN
      lives_next       = 2'd3;
`endif
    end
  end

  assign o_gameplay    = state;
  assign o_clear       = clear;
  assign o_clear_score = clear_score;
  assign o_level       = level;
  assign o_enable      = enable;
`ifdef GAME_SEQUENCER_LIVES_EN
  assign o_lives       = lives;
`else
  assign o_lives       = 2'd0;
`endif

endmodule
`default_nettype wire
